// File: rtl/debounce_sync.sv
// debounce_sync: synchroniser + stability-window debouncer with rise/fall pulses; optional glitch counter under DEBOUNCE_SYNC_GLITCH_CNT_EN
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_raw,
  output logic                a_clean,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {IDLE, QUALIFY} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] s;
  logic [CW-1:0] cnt, cnt_n;
  logic s_out, diff, done;
  assign s_out = s[SYNC_STAGES-1];
  assign busy  = state == QUALIFY;
  always_comb begin
    diff    = s_out != a_clean;
    done    = diff && (32'(cnt) + 32'd1 == 32'(STABLE_CYCLES));
    state_n = diff && !done ? QUALIFY : IDLE;
    cnt_n   = diff && !done ? cnt + CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s       <= '0;
      state   <= IDLE;
      cnt     <= '0;
      a_clean <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      s       <= {s[SYNC_STAGES-2:0], a_raw};
      state   <= state_n;
      cnt     <= cnt_n;
      a_clean <= a_clean ^ done;
      rise    <= done && !a_clean;
      fall    <= done && a_clean;
    end
  end
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] gcnt;
  logic glitch;
  // a qualification that falls back to the current level without toggling
  assign glitch = busy && !diff;
  always_ff @(posedge clk) begin
    if (rst) gcnt <= '0;
    else if (glitch && !(&gcnt)) gcnt <= gcnt + GLITCH_W'(1);
  end
  assign glitch_cnt = gcnt;
`else
  assign glitch_cnt = '0;
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: vector table, corner sequences and randomized run against a sample-window model
module tb_debounce_sync;
  localparam int SS = 2, SC = 4, GW = 8;
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  localparam bit GL_ON = 1'b1;
`else
  localparam bit GL_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, a_raw = 1'b0;
  logic a_clean, rise, fall, busy;
  logic [GW-1:0] glitch_cnt;
  debounce_sync #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .GLITCH_W(GW)) dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .a_clean(a_clean), .rise(rise),
    .fall(fall), .busy(busy), .glitch_cnt(glitch_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit hist[$], so[$];
  bit m_clean, m_rise, m_fall, m_busy;
  int m_gl;
  typedef struct {bit r; bit a; bit [3:0] exp; int gl;} vec_t;
  vec_t tv[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a_clean toggles once the last SC synchronised samples all differ from it
  task automatic step(input bit r, input bit a);
    bit sval, tog, pb;
    rst = r;
    a_raw = a;
    @(posedge clk);
    if (r) begin
      hist.delete();
      so.delete();
      {m_clean, m_rise, m_fall, m_busy} = 4'b0;
      m_gl = 0;
    end else begin
      sval = hist.size() >= SS ? hist[hist.size()-SS] : 1'b0;
      hist.push_back(a);
      so.push_back(sval);
      tog = so.size() >= SC;
      for (int i = 1; i <= SC; i++) if (tog && so[so.size()-i] == m_clean) tog = 1'b0;
      pb = m_busy;
      m_rise = tog && !m_clean;
      m_fall = tog && m_clean;
      m_busy = !tog && sval != m_clean;
      if (GL_ON && pb && sval == m_clean && m_gl < (1 << GW) - 1) m_gl++;
      if (tog) m_clean = !m_clean;
    end
    #1;
    check("model", {20'b0, a_clean, rise, fall, busy, glitch_cnt},
          {20'b0, m_clean, m_rise, m_fall, m_busy, GW'(m_gl)});
  endtask
  task automatic add(input bit r, input bit a, input bit [3:0] e, input int g);
    vec_t v;
    v.r = r; v.a = a; v.exp = e; v.gl = g;
    tv.push_back(v);
  endtask
  initial begin
    int nr, nf, rpos, fpos;
    bit lvl;
    int len;
    repeat (3) add(1, 1, 4'b0000, 0);
    add(0, 1, 4'b0000, 0); add(0, 1, 4'b0000, 0);
    add(0, 1, 4'b0001, 0); add(0, 1, 4'b0001, 0); add(0, 1, 4'b0001, 0);
    add(0, 1, 4'b1100, 0); add(0, 1, 4'b1000, 0); add(0, 1, 4'b1000, 0);
    add(0, 0, 4'b1000, 0); add(0, 0, 4'b1000, 0);
    add(0, 0, 4'b1001, 0); add(0, 0, 4'b1001, 0); add(0, 0, 4'b1001, 0);
    add(0, 0, 4'b0010, 0); add(0, 0, 4'b0000, 0);
    add(0, 1, 4'b0000, 0); add(0, 1, 4'b0000, 0);
    add(0, 0, 4'b0001, 0); add(0, 0, 4'b0001, 0);
    add(0, 0, 4'b0000, 1); add(0, 0, 4'b0000, 1);
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].a);
      check($sformatf("vec%0d", i), {28'b0, a_clean, rise, fall, busy}, {28'b0, tv[i].exp});
      check($sformatf("vec%0d_gl", i), 32'(glitch_cnt), GL_ON ? tv[i].gl : 0);
    end
    nr = 0;
    repeat (3) begin step(0, 1); nr += int'(rise); end
    repeat (10) begin step(0, 0); nr += int'(rise); end
    check("reject3_rise", nr, 0);
    check("reject3_clean", 32'(a_clean), 0);
    rpos = -1; fpos = -1; nr = 0; nf = 0;
    for (int k = 1; k <= 16; k++) begin
      step(0, k <= 4);
      if (rise) begin nr++; rpos = k; end
      if (fall) begin nf++; fpos = k; end
    end
    check("accept4_rise_edge", rpos, 6);
    check("accept4_fall_edge", fpos, 10);
    check("accept4_pulses", nr + nf, 2);
    repeat (4) step(0, 1);
    check("midq_busy", 32'(busy), 1);
    step(1, 1);
    check("midq_rst_busy", {29'b0, busy, rise, fall}, 0);
    rpos = -1; nr = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 1);
      if (rise) begin nr++; rpos = k; end
    end
    check("midq_requal_edge", rpos, 6);
    check("midq_requal_count", nr, 1);
    repeat (300) begin
      repeat (2) step(0, 0);
      repeat (4) step(0, 1);
    end
    check("saturate", 32'(glitch_cnt), GL_ON ? 255 : 0);
    check("saturate_clean", 32'(a_clean), 1);
    for (int i = 0; i < 400; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) step($urandom_range(0, 59) == 0, lvl);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage for asynchronous single-bit inputs such as buttons, switches and external strobes. It synchronises the raw input into `clk`, rejects pulses shorter than a programmable stability window, and produces a clean level plus one-cycle rise and fall pulses. `a_clean` is the intended `a` input of the downstream edge and pulse detectors. `rise` and `fall` serve consumers that need the edge directly.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth. Legal range is 2 or more.
- `STABLE_CYCLES`, default 4: number of consecutive synchronised samples that must differ from `a_clean` before it toggles. Legal range is 1 or more.
- `GLITCH_W`, default 8: width of the glitch counter.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `a_raw`  in  1: asynchronous raw input.
- `a_clean`  out  1: debounced level, registered.
- `rise`  out  1: one-cycle pulse, registered.
- `fall`  out  1: one-cycle pulse, registered.
- `busy`  out  1: high while the FSM is in QUALIFY.
- `glitch_cnt`  out  `GLITCH_W`: count of rejected transitions (see Configuration).

## Operation

Synchroniser:
- A shift chain `s[SYNC_STAGES-1:0]` samples `a_raw` into `s[0]`.
- `s_out` is the last stage of the chain.

FSM state and counter:
- States are IDLE and QUALIFY.
- Stability counter `cnt` is `$clog2(STABLE_CYCLES+1)` bits, unsigned.

Evaluation at every clock edge when not in reset, based on `s_out` versus `a_clean`:
- **Equal:**
  - `cnt` is set to 0 and the next state is IDLE.
  - If the current state was QUALIFY, the transition is a glitch; see Configuration.
- **Different, and `cnt+1 == STABLE_CYCLES`:**
  - `a_clean` toggles.
  - `rise` is set if the new value is 1; `fall` is set if the new value is 0.
  - `cnt` is set to 0 and the next state is IDLE.
- **Different, otherwise:**
  - `cnt` is set to `cnt+1` and the next state is QUALIFY.

Other rules:
- `rise` and `fall` are cleared on every edge where no toggle occurs. They are never high together and never high for two consecutive cycles.
- `busy` is decoded directly from the state register.
- With `STABLE_CYCLES=1`, QUALIFY is never entered. `a_clean` follows `s_out` with one cycle of delay, and no glitch is ever counted.
- Reset mid-QUALIFY discards the partial count. No pulse is issued.
- After reset, `a_clean=0`. A raw input that is already high therefore produces a normal qualified `rise`.

## Timing

Reset values:
- All synchroniser stages, `a_clean`, `rise`, `fall` and `cnt` are 0.
- State is IDLE, so `busy=0`.
- `glitch_cnt=0`.

Latency:
- Let `a_raw` change before edge E0 and stay stable.
- `s_out` shows the new value after edge E0+SYNC_STAGES-1.
- `a_clean` and the matching pulse show it after edge E0+SYNC_STAGES+STABLE_CYCLES-1.
- With defaults, this is after the 6th edge counted from E0 inclusive. The pulse is high for exactly that one cycle.

Rejection window:
- Any synchronised excursion lasting fewer than `STABLE_CYCLES` samples produces no change on `a_clean`.

## Configuration

Macro `DEBOUNCE_SYNC_GLITCH_CNT_EN`.

When defined:
- `glitch_cnt` increments by 1 on each QUALIFY→IDLE transition that occurs without a toggle.
- It saturates at all-ones and does not wrap.
- It clears only on `rst`.

When undefined:
- The counter logic is not built.
- `glitch_cnt` is tied to 0. The port remains so that instantiations do not change.

## Test plan

Defaults, with the macro defined unless stated.

1. **Reset:** hold `rst` 3 cycles with `a_raw=1` → all outputs 0 during reset. After release, `rise` pulses once, exactly after the 6th edge following release; `a_clean=1` thereafter.
2. **Clean step:** `a_raw` goes 0→1, held 20 cycles, then 1→0 → one `rise` after the 6th edge from the rising change and one `fall` after the 6th edge from the falling change. Each pulse is 1 cycle wide. `busy` is high for 3 cycles before each toggle.
3. **Glitch:** `a_raw` high for 2 cycles, then low → `a_clean` stays 0, no pulse, `busy` high 2 cycles, `glitch_cnt=1`. With the macro undefined: identical behaviour, but `glitch_cnt=0`.
4. **Boundary:** pulse of 3 cycles → rejected. Pulse of 4 cycles → accepted, with `rise` then `fall` each delayed 6 edges.
5. **Saturation:** 300 glitches with `GLITCH_W=8` → `glitch_cnt=255`.
6. **Reset mid-operation:** assert `rst` while `busy=1` and `cnt=2` → after release `busy=0`, no pulse, and requalification starts from 0.
